// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: DEPTH x WIDTH register file with two combinational read
// ports, one write port, a pending-producer scoreboard bit per register, and
// a bulk-clear sequencer that zeroes one entry per cycle.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data write port (also retires the pending bit)
//   rd_addr1/rd_data1     read port 1 (combinational, optional forwarding)
//   rd_addr2/rd_data2     read port 2
//   alloc_en/alloc_addr   mark a destination as awaiting its producer
//   busy1/busy2           pending status of the read-port indices
//   clr_req/clr_busy      start / in-progress flag of the bulk clear
module regfile_scoreboard #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_addr,
  output logic             busy1,
  output logic             busy2,
  input  logic             clr_req,
  output logic             clr_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;

  logic wr_ok;
  logic alloc_ok;
  logic fwd_ok;
  logic fwd1;
  logic fwd2;
  logic zero1;
  logic zero2;

  // Index 0 swallows writes and allocations when it is the hardwired zero.
  assign wr_ok    = wr_en    && !(ZERO_REG && (wr_addr    == '0));
  assign alloc_ok = alloc_en && !(ZERO_REG && (alloc_addr == '0));

  // Forwarding only when the write would actually land this edge
  // (not in reset, not during a clear).
  assign fwd_ok = BYPASS && rst_n && (state == IDLE) && wr_en;
  assign fwd1   = fwd_ok && (wr_addr == rd_addr1);
  assign fwd2   = fwd_ok && (wr_addr == rd_addr2);
  assign zero1  = ZERO_REG && (rd_addr1 == '0);
  assign zero2  = ZERO_REG && (rd_addr2 == '0);

  always_comb begin
    rd_data1 = mem[rd_addr1];
    rd_data2 = mem[rd_addr2];
    if (fwd1) rd_data1 = wr_data;
    if (fwd2) rd_data2 = wr_data;
    if (zero1) rd_data1 = '0;
    if (zero2) rd_data2 = '0;
    // The forwarded write retires the producer, so the reader is not stalled.
    busy1 = pending[rd_addr1] && !fwd1;
    busy2 = pending[rd_addr2] && !fwd2;
  end

  assign clr_busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == IDLE) begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      if (wr_en) pending[wr_addr] <= 1'b0;
      // Set after the clear so a same-index alloc+write leaves it pending.
      if (alloc_ok) pending[alloc_addr] <= 1'b1;
      if (clr_req) begin
        state <= CLEAR;
        cnt   <= '0;
      end
    end else begin
      mem[cnt]     <= '0;
      pending[cnt] <= 1'b0;
      if (cnt == AW'(DEPTH - 1)) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

endmodule
